// File: rtl/vmem_uart_dump.sv
// rtl/vmem_uart_dump.sv - hex dump of every vmem_reg change over an 8N1 UART line
//
// Purpose: watches the CPU's 64-bit vmem_reg and, whenever it changes, sends the
// new value as 16 uppercase hex digits (MS nibble first) followed by CR LF.
// Only the newest value is kept while a frame is in flight.
//
// Ports:
//   sys_clk    in   1   system clock, posedge
//   sys_rst    in   1   synchronous reset, active-low
//   vmem_reg   in  64   value to monitor
//   uart_tx    out  1   serial line, 8N1, LSB first, idle high (registered)
//   busy       out  1   high while a dump frame is on the line
//   pending    out  1   a captured value is waiting to be sent
//   dump_count out 16   completed dumps, wraps at 0xFFFF
module vmem_uart_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] vmem_reg,
  output logic        uart_tx,
  output logic        busy,
  output logic        pending,
  output logic [15:0] dump_count
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [4:0]       char_idx_q, char_idx_d;
  logic [63:0]      txbuf_q, txbuf_d;
  logic [63:0]      last_seen_q, last_seen_d;
  logic [63:0]      snapshot_q, snapshot_d;
  logic             pending_q, pending_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [15:0]      dump_count_q, dump_count_d;

  logic             bit_end;
  logic [2:0]       next_bit;
  logic [3:0]       nibble;
  logic [7:0]       cur_char;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign next_bit = bit_idx_q + 3'd1;
  // Nibble for char_idx 0..15, MS nibble first.
  assign nibble   = 4'(txbuf_q >> (6'd60 - {char_idx_q[3:0], 2'b00}));

  always_comb begin
    cur_char = 8'h0A;
    if (char_idx_q == 5'd16) begin
      cur_char = 8'h0D;
    end else if (char_idx_q < 5'd16) begin
      cur_char = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    char_idx_d   = char_idx_q;
    txbuf_d      = txbuf_q;
    last_seen_d  = last_seen_q;
    snapshot_d   = snapshot_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    tx_d         = tx_q;
    dump_count_d = dump_count_q;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pending_q) begin
          // Start bit goes out on the same edge that consumes pending.
          txbuf_d    = snapshot_q;
          char_idx_d = 5'd0;
          pending_d  = 1'b0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_char[0];
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_char[next_bit];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (char_idx_q < 5'd17) begin
            char_idx_d = char_idx_q + 5'd1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            dump_count_d = dump_count_q + 16'd1;
            busy_d       = 1'b0;
            tx_d         = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture runs in every state and overrides the IDLE clear of pending,
    // so a change on the consuming edge is never lost.
    if (vmem_reg != last_seen_q) begin
      last_seen_d = vmem_reg;
      snapshot_d  = vmem_reg;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      char_idx_q   <= '0;
      txbuf_q      <= '0;
      last_seen_q  <= '0;
      snapshot_q   <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      tx_q         <= 1'b1;
      dump_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      char_idx_q   <= char_idx_d;
      txbuf_q      <= txbuf_d;
      last_seen_q  <= last_seen_d;
      snapshot_q   <= snapshot_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      tx_q         <= tx_d;
      dump_count_q <= dump_count_d;
    end
  end

  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign pending    = pending_q;
  assign dump_count = dump_count_q;

endmodule

// File: tb/tb_vmem_uart_dump.sv
// tb/tb_vmem_uart_dump.sv - self-checking bench for vmem_uart_dump
module tb_vmem_uart_dump;

  localparam int CPB      = 4;
  localparam int CHAR_CYC = 10 * CPB;
  localparam int DUMP_CYC = 18 * CHAR_CYC;

  localparam logic [7:0] LIT1 [18] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                       8'h36, 8'h37, 8'h38, 8'h39, 8'h41, 8'h42,
                                       8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};

  logic        sys_clk;
  logic        sys_rst;
  logic [63:0] vmem_reg;
  logic        uart_tx;
  logic        busy;
  logic        pending;
  logic [15:0] dump_count;

  vmem_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .vmem_reg  (vmem_reg),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .pending   (pending),
    .dump_count(dump_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int  nvec;
  int  nfail;
  bit  done;
  bit  preload_pulse;
  string hexs = "0123456789ABCDEF";

  // Model: pending value, active frame with its cycle offset, dump counter.
  logic [63:0] m_last, m_snap, m_val;
  bit          m_pend, m_active, m_started;
  int          m_n;
  logic [15:0] m_count;

  logic [7:0]  rx_q [$];

  function automatic logic [7:0] frame_char(input logic [63:0] v, input int c);
    if (c == 16) return 8'h0D;
    if (c == 17) return 8'h0A;
    return hexs[int'((v >> (60 - 4 * c)) & 64'hF)];
  endfunction

  // Line level at cycle n of a frame: per char 1 start, 8 data LSB first, 1 stop.
  function automatic logic frame_bit(input logic [63:0] v, input int n);
    int c;
    int b;
    logic [7:0] ch;
    c = n / CHAR_CYC;
    b = (n / CPB) % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    ch = frame_char(v, c);
    return ch[b-1];
  endfunction

  initial begin
    m_started = 0; m_pend = 0; m_active = 0; m_n = 0;
    m_last = '0; m_snap = '0; m_val = '0; m_count = '0;
    forever begin
      @(posedge sys_clk);
      m_started = 1;
      if (!sys_rst) begin
        m_last = '0; m_snap = '0; m_pend = 0; m_active = 0; m_n = 0; m_count = '0;
      end else begin
        if (preload_pulse) m_count = 16'hFFFF;
        if (m_active) begin
          m_n++;
          if (m_n == DUMP_CYC) begin
            m_active = 0;
            m_count  = m_count + 16'd1;
          end
        end else if (m_pend) begin
          m_active = 1; m_n = 0; m_val = m_snap; m_pend = 0;
        end
        if (vmem_reg != m_last) begin
          m_last = vmem_reg; m_snap = vmem_reg; m_pend = 1;
        end
      end
    end
  end

  // UART receiver, sampling mid-bit.
  initial begin
    bit act;
    int t;
    logic [7:0] sh;
    act = 0; t = 0; sh = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
        act = 0;
      end else if (!act) begin
        if (uart_tx === 1'b0) begin act = 1; t = 0; end
      end else begin
        t++;
        if (t >= CPB + CPB / 2 && t < 9 * CPB && (t % CPB) == CPB / 2) sh[t / CPB - 1] = uart_tx;
        if (t == 9 * CPB + CPB / 2 && uart_tx === 1'b1) rx_q.push_back(sh);
        if (t == 10 * CPB - 1) act = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] act;
    act = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
    chk($sformatf("%s[%0d]", name, idx), {56'd0, act}, {56'd0, exp});
  endtask

  task automatic wait_count(input logic [15:0] target, input int limit);
    int k;
    k = 0;
    while (dump_count !== target && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
  endtask

  task automatic count_busy(output int len);
    len = 0;
    while (busy === 1'b1 && len < 2000) begin
      len++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    int base;
    int len;
    bit seen;
    logic [63:0] va, vb;
    nvec = 0; nfail = 0; done = 0; preload_pulse = 0;
    sys_rst = 1'b0; vmem_reg = '0;
    fork
      begin : monitor
        logic etx;
        while (!done) begin
          @(negedge sys_clk);
          if (m_started) begin
            etx = m_active ? frame_bit(m_val, m_n) : 1'b1;
            nvec++;
            if (uart_tx !== etx || busy !== m_active || pending !== m_pend || dump_count !== m_count) begin
              nfail++;
              $display("FAIL cycle t=%0t tx/busy/pend/cnt: got %b/%b/%b/%0h expected %b/%b/%b/%0h",
                       $time, uart_tx, busy, pending, dump_count, etx, m_active, m_pend, m_count);
            end
          end
        end
      end
      begin : stim
        repeat (3) @(negedge sys_clk);
        chk("rst_tx", {63'd0, uart_tx}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pend", {63'd0, pending}, 64'd0);
        chk("rst_cnt", {48'd0, dump_count}, 64'd0);
        sys_rst = 1'b1;
        seen = 0;
        repeat (2000) begin
          @(negedge sys_clk);
          if (busy !== 1'b0 || uart_tx !== 1'b1) seen = 1;
        end
        chk("zero_quiet", {63'd0, seen}, 64'd0);
        chk("zero_cnt", {48'd0, dump_count}, 64'd0);

        base = rx_q.size();
        vmem_reg = 64'h0123456789ABCDEF;
        @(negedge sys_clk);
        chk("cap_pend", {63'd0, pending}, 64'd1);
        chk("cap_tx", {63'd0, uart_tx}, 64'd1);
        @(negedge sys_clk);
        chk("lat_tx", {63'd0, uart_tx}, 64'd0);
        chk("lat_busy", {63'd0, busy}, 64'd1);
        len = 0;
        while (busy === 1'b1 && len < 2000) begin
          if (len == 100) vmem_reg = 64'h1;
          if (len == 200) vmem_reg = 64'h2;
          if (len == 300) vmem_reg = '1;
          len++;
          @(negedge sys_clk);
        end
        chk("d1_len", len, 720);
        chk("d1_cnt", {48'd0, dump_count}, 64'd1);
        chk("gap_tx", {63'd0, uart_tx}, 64'd1);
        @(negedge sys_clk);
        chk("gap_start", {63'd0, uart_tx}, 64'd0);
        count_busy(len);
        chk("d2_len", len, 720);
        chk("d2_cnt", {48'd0, dump_count}, 64'd2);
        chk("d2_pend", {63'd0, pending}, 64'd0);
        for (int i = 0; i < 18; i++) chk_byte("d1_byte", base + i, LIT1[i]);
        for (int i = 0; i < 16; i++) chk_byte("d2_byte", base + 18 + i, 8'h46);
        chk_byte("d2_byte", base + 34, 8'h0D);
        chk_byte("d2_byte", base + 35, 8'h0A);

        repeat (5) @(negedge sys_clk);
        base = rx_q.size();
        va = 64'h00000000DEADBEEF;
        vb = 64'hCAFEF00D12345678;
        vmem_reg = va;
        @(negedge sys_clk);
        vmem_reg = vb;
        wait_count(16'd4, 3 * DUMP_CYC);
        chk("same_edge_cnt", {48'd0, dump_count}, 64'd4);
        for (int i = 0; i < 18; i++) chk_byte("a_byte", base + i, frame_char(va, i));
        for (int i = 0; i < 18; i++) chk_byte("b_byte", base + 18 + i, frame_char(vb, i));
        chk_byte("pin_dead", base + 8, 8'h44);
        chk_byte("pin_cafe", base + 18, 8'h43);

        repeat (5) @(negedge sys_clk);
        vmem_reg = 64'h0F0F0F0F0F0F0F0F;
        len = 0;
        while (busy !== 1'b1 && len < 100) begin @(negedge sys_clk); len++; end
        repeat (100) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("midrst_tx", {63'd0, uart_tx}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_cnt", {48'd0, dump_count}, 64'd0);
        chk("midrst_pend", {63'd0, pending}, 64'd0);
        @(negedge sys_clk);
        base = rx_q.size();
        sys_rst = 1'b1;
        wait_count(16'd1, 2 * DUMP_CYC);
        chk("post_rst_cnt", {48'd0, dump_count}, 64'd1);
        for (int i = 0; i < 16; i++) chk_byte("rr_byte", base + i, (i % 2 == 0) ? 8'h30 : 8'h46);
        chk_byte("rr_byte", base + 16, 8'h0D);
        chk_byte("rr_byte", base + 17, 8'h0A);

        repeat (5) @(negedge sys_clk);
        #1;
        force dut.dump_count_q = 16'hFFFF;
        preload_pulse = 1;
        @(negedge sys_clk);
        #1;
        release dut.dump_count_q;
        preload_pulse = 0;
        @(negedge sys_clk);
        chk("preload", {48'd0, dump_count}, 64'hFFFF);
        base = rx_q.size();
        vmem_reg = 64'h1;
        wait_count(16'd0, 2 * DUMP_CYC);
        chk("wrap_cnt", {48'd0, dump_count}, 64'd0);
        chk("wrap_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 15; i++) chk_byte("w_byte", base + i, 8'h30);
        chk_byte("w_byte", base + 15, 8'h31);
        chk_byte("w_byte", base + 17, 8'h0A);

        repeat (3) @(negedge sys_clk);
        done = 1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
